// File: rtl/lsu_buffered_if.sv
// rtl/lsu_buffered_if.sv - core/memory/writeback bundle for one buffered LSU slot
//
// Ports (slave = LSU side, master = core/memory environment side):
//   req_*      op from ID/EX with valid/ready handshake
//   mem_req_*  single memory request channel (stores and loads), plus mem_we/addr/wdata/be
//   mem_rsp_*  load response
//   wb_*       register-file write port
//   misalign_err, sb_count, ex_is_load  status toward the core
interface lsu_buffered_if #(
    parameter int XLEN     = 32,
    parameter int IMM_W    = 12,
    parameter int SB_DEPTH = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_is_load;
    logic [1:0]                    req_size;
    logic                          req_zero_ext;
    logic [4:0]                    req_rd;
    logic [XLEN-1:0]               req_base;
    logic [IMM_W-1:0]              req_imm;
    logic [XLEN-1:0]               req_wdata;

    logic                          mem_req_valid;
    logic                          mem_req_ready;
    logic                          mem_we;
    logic [XLEN-1:0]               mem_addr;
    logic [XLEN-1:0]               mem_wdata;
    logic [XLEN/8-1:0]             mem_be;
    logic                          mem_rsp_valid;
    logic [XLEN-1:0]               mem_rdata;

    logic                          wb_valid;
    logic [4:0]                    wb_rd;
    logic [XLEN-1:0]               wb_data;
    logic                          misalign_err;
    logic [$clog2(SB_DEPTH):0]     sb_count;
    logic                          ex_is_load;

    modport slave (
        input  req_valid, req_is_load, req_size, req_zero_ext, req_rd,
               req_base, req_imm, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
               wb_valid, wb_rd, wb_data, misalign_err, sb_count, ex_is_load
    );

    modport master (
        output req_valid, req_is_load, req_size, req_zero_ext, req_rd,
               req_base, req_imm, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
               wb_valid, wb_rd, wb_data, misalign_err, sb_count, ex_is_load
    );
endinterface

// File: rtl/lsu_buffered.sv
// rtl/lsu_buffered.sv - buffered load/store unit for one VLIW LSU slot
//
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   bus   lsu_buffered_if.slave: core request, memory request/response,
//         writeback and status signals
module lsu_buffered #(
    parameter int XLEN     = 32,
    parameter int IMM_W    = 12,
    parameter int SB_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    lsu_buffered_if.slave   bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REQ, S_WAIT} state_t;

    state_t             state_q;
    logic               ready_en_q;
    logic               misalign_q;
    logic               wb_valid_q;
    logic [4:0]         wb_rd_q;
    logic [XLEN-1:0]    wb_data_q;

    logic [XLEN-1:0]    ld_addr_q;
    logic [OFF_W-1:0]   ld_off_q;
    logic [1:0]         ld_size_q;
    logic               ld_zext_q;
    logic [4:0]         ld_rd_q;

    logic [XLEN-1:0]    sb_addr_q [SB_DEPTH];
    logic [XLEN-1:0]    sb_data_q [SB_DEPTH];
    logic [NB-1:0]      sb_be_q   [SB_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [XLEN-1:0]    ea;
    logic [XLEN-1:0]    ea_aligned;
    logic [OFF_W-1:0]   off;
    logic               bad;
    logic [7:0]         be_mask;
    logic [NB-1:0]      st_be;
    logic [XLEN-1:0]    st_data;
    logic               sb_empty;
    logic               sb_full;
    logic               drain_act;
    logic               pop;
    logic               push;
    logic               ld_go;
    logic               req_ready;
    logic               accept;

    logic [XLEN-1:0]    ld_shift;
    logic [XLEN-1:0]    ld_result;
    logic               ld_sign;
    int                 ld_bits;

    assign ea         = bus.req_base + {{(XLEN-IMM_W){bus.req_imm[IMM_W-1]}}, bus.req_imm};
    assign ea_aligned = {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign off        = ea[OFF_W-1:0];

    // Size 3 is illegal on a 32-bit datapath; fold that into the same error path.
    always_comb begin
        bad     = 1'b0;
        be_mask = 8'h00;
        case (bus.req_size)
            2'd0: begin bad = 1'b0;                    be_mask = 8'h01; end
            2'd1: begin bad = ea[0];                   be_mask = 8'h03; end
            2'd2: begin bad = |ea[1:0];                be_mask = 8'h0F; end
            default: begin bad = (|ea[2:0]) || (XLEN == 32); be_mask = 8'hFF; end
        endcase
    end

    assign st_be   = NB'(be_mask) << off;
    assign st_data = bus.req_wdata << {off, 3'b000};

    assign sb_empty  = (cnt_q == '0);
    assign sb_full   = (cnt_q == CNT_W'(SB_DEPTH));
    // Stores only drain while no load owns the memory port, keeping program order.
    assign drain_act = !sb_empty && (state_q == S_IDLE || state_q == S_DRAIN);
    assign pop       = drain_act && bus.mem_req_ready;

    // A pop in the same cycle frees a slot, so a full buffer can still take a store.
    assign req_ready = ready_en_q && (state_q == S_IDLE) && (bus.req_is_load || !sb_full || pop);
    assign accept    = bus.req_valid && req_ready;
    assign push      = accept && !bus.req_is_load && !bad;
    assign ld_go     = accept && bus.req_is_load && !bad;

    // Memory outputs come only from registered state, so they hold steady until accepted.
    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_be        = '0;
        if (state_q == S_REQ) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_addr      = ld_addr_q;
        end else if (drain_act) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_we        = 1'b1;
            bus.mem_addr      = sb_addr_q[rd_ptr_q];
            bus.mem_wdata     = sb_data_q[rd_ptr_q];
            bus.mem_be        = sb_be_q[rd_ptr_q];
        end
    end

    always_comb begin
        ld_shift = bus.mem_rdata >> {ld_off_q, 3'b000};
        case (ld_size_q)
            2'd0:    begin ld_bits = 8;    ld_sign = ld_shift[7];      end
            2'd1:    begin ld_bits = 16;   ld_sign = ld_shift[15];     end
            2'd2:    begin ld_bits = 32;   ld_sign = ld_shift[31];     end
            default: begin ld_bits = XLEN; ld_sign = ld_shift[XLEN-1]; end
        endcase
        if (ld_zext_q) begin
            ld_sign = 1'b0;
        end
        ld_result = '0;
        for (int i = 0; i < XLEN; i++) begin
            ld_result[i] = (i < ld_bits) ? ld_shift[i] : ld_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            misalign_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            ld_addr_q  <= '0;
            ld_off_q   <= '0;
            ld_size_q  <= '0;
            ld_zext_q  <= 1'b0;
            ld_rd_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ready_en_q <= 1'b1;
            misalign_q <= accept && bad;
            wb_valid_q <= 1'b0;

            if (push) begin
                sb_addr_q[wr_ptr_q] <= ea_aligned;
                sb_data_q[wr_ptr_q] <= st_data;
                sb_be_q[wr_ptr_q]   <= st_be;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (ld_go) begin
                        ld_addr_q <= ea_aligned;
                        ld_off_q  <= off;
                        ld_size_q <= bus.req_size;
                        ld_zext_q <= bus.req_zero_ext;
                        ld_rd_q   <= bus.req_rd;
                        state_q   <= sb_empty ? S_REQ : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (sb_empty) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    if (bus.mem_rsp_valid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= ld_rd_q;
                        wb_data_q  <= ld_result;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.misalign_err = misalign_q;
    assign bus.sb_count     = cnt_q;
    assign bus.ex_is_load   = (state_q != S_IDLE);
endmodule

// File: tb/tb_lsu_buffered.sv
// tb/tb_lsu_buffered.sv - directed self-checking bench for lsu_buffered (32- and 64-bit)
module tb_lsu_buffered;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    lsu_buffered_if #(.XLEN(32), .IMM_W(12), .SB_DEPTH(4)) a ();
    lsu_buffered_if #(.XLEN(64), .IMM_W(12), .SB_DEPTH(4)) b ();

    lsu_buffered #(.XLEN(32), .IMM_W(12), .SB_DEPTH(4)) u_a (.clk(clk), .rst(rst_a), .bus(a.slave));
    lsu_buffered #(.XLEN(64), .IMM_W(12), .SB_DEPTH(4)) u_b (.clk(clk), .rst(rst_b), .bus(b.slave));

    logic [31:0] st_base [5];
    logic [1:0]  st_size [5];
    logic [31:0] st_wd   [5];
    logic [31:0] ex_addr [5];
    logic [31:0] ex_data [5];
    logic [3:0]  ex_be   [5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic ld, input logic [1:0] sz, input logic zx, input logic [4:0] rd,
                           input logic [31:0] base, input logic [11:0] imm, input logic [31:0] wd);
        int n;
        a.req_valid = 1'b1; a.req_is_load = ld; a.req_size = sz; a.req_zero_ext = zx;
        a.req_rd = rd; a.req_base = base; a.req_imm = imm; a.req_wdata = wd;
        #1;
        n = 0;
        while (!a.req_ready && n < 20) begin tick; n++; end
        if (n == 20) check("a_accept_timeout", 64'd0, 64'd1);
        tick;
        a.req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic ld, input logic [1:0] sz, input logic zx, input logic [4:0] rd,
                           input logic [63:0] base, input logic [11:0] imm, input logic [63:0] wd);
        int n;
        b.req_valid = 1'b1; b.req_is_load = ld; b.req_size = sz; b.req_zero_ext = zx;
        b.req_rd = rd; b.req_base = base; b.req_imm = imm; b.req_wdata = wd;
        #1;
        n = 0;
        while (!b.req_ready && n < 20) begin tick; n++; end
        if (n == 20) check("b_accept_timeout", 64'd0, 64'd1);
        tick;
        b.req_valid = 1'b0;
    endtask

    // Waits for the load request, checks it, completes it and checks the writeback pulse.
    task automatic rsp_a(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                         input logic [4:0] exp_rd, input logic [31:0] exp_wb);
        int n;
        n = 0;
        while (!(a.mem_req_valid && !a.mem_we) && n < 20) begin tick; n++; end
        if (n == 20) check({tag, "_req_timeout"}, 64'd0, 64'd1);
        check({tag, "_addr"}, 64'(a.mem_addr), 64'(exp_addr));
        check({tag, "_be"}, 64'(a.mem_be), 64'h0);
        a.mem_req_ready = 1'b1;
        tick;
        a.mem_req_ready = 1'b0;
        a.mem_rsp_valid = 1'b1;
        a.mem_rdata = rdata;
        tick;
        a.mem_rsp_valid = 1'b0;
        check({tag, "_wbv"}, 64'(a.wb_valid), 64'h1);
        check({tag, "_rd"}, 64'(a.wb_rd), 64'(exp_rd));
        check({tag, "_data"}, 64'(a.wb_data), 64'(exp_wb));
        tick;
        check({tag, "_wbv_pulse"}, 64'(a.wb_valid), 64'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        a.req_valid = 0; a.req_is_load = 0; a.req_size = 0; a.req_zero_ext = 0; a.req_rd = 0;
        a.req_base = 0; a.req_imm = 0; a.req_wdata = 0; a.mem_req_ready = 0; a.mem_rsp_valid = 0; a.mem_rdata = 0;
        b.req_valid = 0; b.req_is_load = 0; b.req_size = 0; b.req_zero_ext = 0; b.req_rd = 0;
        b.req_base = 0; b.req_imm = 0; b.req_wdata = 0; b.mem_req_ready = 0; b.mem_rsp_valid = 0; b.mem_rdata = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick;

        check("rst_ready", 64'(a.req_ready), 64'h0);
        check("rst_mvalid", 64'(a.mem_req_valid), 64'h0);
        check("rst_sbcnt", 64'(a.sb_count), 64'h0);
        check("rst_exload", 64'(a.ex_is_load), 64'h0);
        check("rst_wbv", 64'(a.wb_valid), 64'h0);
        check("rst_mis", 64'(a.misalign_err), 64'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("rel_ready_same_cycle", 64'(a.req_ready), 64'h0);
        tick;
        check("rel_ready_next_cycle", 64'(a.req_ready), 64'h1);

        // Store word then load it back: store must reach memory first.
        issue_a(1'b0, 2'd2, 1'b0, 5'd0, 32'h100, 12'd4, 32'hDEADBEEF);
        check("st_sbcnt", 64'(a.sb_count), 64'h1);
        check("st_mis", 64'(a.misalign_err), 64'h0);
        check("st_mvalid", 64'(a.mem_req_valid), 64'h1);
        check("st_we", 64'(a.mem_we), 64'h1);
        check("st_addr", 64'(a.mem_addr), 64'h104);
        check("st_be", 64'(a.mem_be), 64'hF);
        check("st_wdata", 64'(a.mem_wdata), 64'hDEADBEEF);
        issue_a(1'b1, 2'd2, 1'b0, 5'd5, 32'h104, 12'd0, 32'h0);
        check("ld_drain_exload", 64'(a.ex_is_load), 64'h1);
        check("ld_drain_we_first", 64'(a.mem_we), 64'h1);
        a.mem_req_ready = 1'b1;
        tick;
        a.mem_req_ready = 1'b0;
        check("ld_drain_sbcnt", 64'(a.sb_count), 64'h0);
        rsp_a("ldw", 32'h104, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);

        // Sub-word loads with extension.
        issue_a(1'b1, 2'd0, 1'b0, 5'd7, 32'h100, 12'd3, 32'h0);
        rsp_a("lb_s", 32'h100, 32'h80123456, 5'd7, 32'hFFFFFF80);
        issue_a(1'b1, 2'd0, 1'b1, 5'd8, 32'h100, 12'd3, 32'h0);
        rsp_a("lb_z", 32'h100, 32'h80123456, 5'd8, 32'h00000080);
        issue_a(1'b1, 2'd1, 1'b0, 5'd9, 32'h100, 12'd2, 32'h0);
        rsp_a("lh_s", 32'h100, 32'h80015555, 5'd9, 32'hFFFF8001);
        issue_a(1'b1, 2'd2, 1'b0, 5'd10, 32'h110, 12'hFF8, 32'h0);
        rsp_a("lw_negimm", 32'h108, 32'h12345678, 5'd10, 32'h12345678);

        // Misaligned / illegal ops.
        issue_a(1'b0, 2'd1, 1'b0, 5'd0, 32'h100, 12'd1, 32'h1234);
        check("sh_mis", 64'(a.misalign_err), 64'h1);
        check("sh_mis_sbcnt", 64'(a.sb_count), 64'h0);
        check("sh_mis_mvalid", 64'(a.mem_req_valid), 64'h0);
        tick;
        check("sh_mis_pulse", 64'(a.misalign_err), 64'h0);
        check("sh_mis_mvalid2", 64'(a.mem_req_valid), 64'h0);
        issue_a(1'b1, 2'd2, 1'b0, 5'd3, 32'h102, 12'd0, 32'h0);
        check("lw_mis", 64'(a.misalign_err), 64'h1);
        check("lw_mis_exload", 64'(a.ex_is_load), 64'h0);
        tick;
        issue_a(1'b1, 2'd3, 1'b0, 5'd3, 32'h0, 12'd0, 32'h0);
        check("ld_illegal", 64'(a.misalign_err), 64'h1);
        tick;
        check("wb_none_after_mis", 64'(a.wb_valid), 64'h0);

        // Fill the buffer, stall, then drain in order while the fifth store enters.
        st_base = '{32'h201, 32'h206, 32'h208, 32'h20F, 32'h300};
        st_size = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
        st_wd   = '{32'hAB, 32'h1234, 32'hCAFEF00D, 32'h77, 32'h55};
        ex_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300};
        ex_data = '{32'h0000AB00, 32'h12340000, 32'hCAFEF00D, 32'h77000000, 32'h00000055};
        ex_be   = '{4'h2, 4'hC, 4'hF, 4'h8, 4'hF};
        for (int i = 0; i < 4; i++) issue_a(1'b0, st_size[i], 1'b0, 5'd0, st_base[i], 12'd0, st_wd[i]);
        check("full_sbcnt", 64'(a.sb_count), 64'h4);
        a.req_valid = 1'b1; a.req_is_load = 1'b0; a.req_size = st_size[4];
        a.req_base = st_base[4]; a.req_imm = 12'd0; a.req_wdata = st_wd[4];
        #1;
        check("full_ready", 64'(a.req_ready), 64'h0);
        tick;
        check("full_sbcnt_hold", 64'(a.sb_count), 64'h4);
        check("full_ready_hold", 64'(a.req_ready), 64'h0);
        check("drain0_addr", 64'(a.mem_addr), 64'(ex_addr[0]));
        check("drain0_data", 64'(a.mem_wdata), 64'(ex_data[0]));
        check("drain0_be", 64'(a.mem_be), 64'(ex_be[0]));
        a.mem_req_ready = 1'b1;
        #1;
        check("full_pop_ready", 64'(a.req_ready), 64'h1);
        tick;
        a.req_valid = 1'b0;
        check("push_pop_sbcnt", 64'(a.sb_count), 64'h4);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("drain%0d_addr", i), 64'(a.mem_addr), 64'(ex_addr[i]));
            check($sformatf("drain%0d_data", i), 64'(a.mem_wdata), 64'(ex_data[i]));
            check($sformatf("drain%0d_be", i), 64'(a.mem_be), 64'(ex_be[i]));
            tick;
        end
        a.mem_req_ready = 1'b0;
        check("drained_sbcnt", 64'(a.sb_count), 64'h0);
        check("drained_mvalid", 64'(a.mem_req_valid), 64'h0);

        // Load behind three buffered stores, with stalls on both request kinds.
        for (int i = 0; i < 3; i++) issue_a(1'b0, 2'd2, 1'b0, 5'd0, 32'h400 + 32'(4 * i), 12'd0, 32'(i + 1));
        issue_a(1'b1, 2'd2, 1'b0, 5'd9, 32'h400, 12'd0, 32'h0);
        check("l3_exload", 64'(a.ex_is_load), 64'h1);
        for (int i = 0; i < 3; i++) begin
            check("l3_st_stable", 64'({a.mem_req_valid, a.mem_we, a.mem_be, a.mem_addr}), {26'd0, 1'b1, 1'b1, 4'hF, 32'h400});
            tick;
        end
        a.mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("l3_pop%0d_addr", i), 64'(a.mem_addr), 64'(32'h400 + 32'(4 * i)));
            check($sformatf("l3_pop%0d_we", i), 64'(a.mem_we), 64'h1);
            tick;
        end
        a.mem_req_ready = 1'b0;
        check("l3_gap_mvalid", 64'(a.mem_req_valid), 64'h0);
        tick;
        for (int i = 0; i < 3; i++) begin
            check("l3_ld_stable", 64'({a.mem_req_valid, a.mem_we, a.mem_be, a.mem_addr}), {26'd0, 1'b1, 1'b0, 4'h0, 32'h400});
            tick;
        end
        rsp_a("l3", 32'h400, 32'h00000001, 5'd9, 32'h00000001);

        // A response outside WAIT must be ignored.
        a.mem_rsp_valid = 1'b1;
        a.mem_rdata = 32'hFFFF;
        tick;
        a.mem_rsp_valid = 1'b0;
        check("spurious_rsp_wbv", 64'(a.wb_valid), 64'h0);
        check("spurious_rsp_exload", 64'(a.ex_is_load), 64'h0);

        // 64-bit datapath.
        issue_b(1'b0, 2'd3, 1'b0, 5'd0, 64'h0, 12'd8, 64'h0123456789ABCDEF);
        check("b_sd_be", 64'(b.mem_be), 64'hFF);
        check("b_sd_addr", b.mem_addr, 64'h8);
        check("b_sd_data", b.mem_wdata, 64'h0123456789ABCDEF);
        b.mem_req_ready = 1'b1; tick; b.mem_req_ready = 1'b0;
        check("b_sd_sbcnt", 64'(b.sb_count), 64'h0);
        issue_b(1'b0, 2'd0, 1'b0, 5'd0, 64'h0, 12'hD, 64'hAB);
        check("b_sb_be", 64'(b.mem_be), 64'h20);
        check("b_sb_addr", b.mem_addr, 64'h8);
        check("b_sb_data", b.mem_wdata, 64'h0000AB0000000000);
        b.mem_req_ready = 1'b1; tick; b.mem_req_ready = 1'b0;
        issue_b(1'b0, 2'd3, 1'b0, 5'd0, 64'h4, 12'd0, 64'h1);
        check("b_sd_mis", 64'(b.misalign_err), 64'h1);
        check("b_sd_mis_sbcnt", 64'(b.sb_count), 64'h0);

        issue_b(1'b1, 2'd2, 1'b0, 5'd4, 64'h10, 12'd4, 64'h0);
        check("b_lw_addr", b.mem_addr, 64'h10);
        check("b_lw_mvalid", 64'({b.mem_req_valid, b.mem_we}), 64'h2);
        b.mem_req_ready = 1'b1; tick; b.mem_req_ready = 1'b0;
        b.mem_rsp_valid = 1'b1; b.mem_rdata = 64'h8000000112345678; tick; b.mem_rsp_valid = 1'b0;
        check("b_lw_wbv", 64'(b.wb_valid), 64'h1);
        check("b_lw_data", b.wb_data, 64'hFFFFFFFF80000001);
        tick;

        // Reset while waiting for load data.
        issue_b(1'b1, 2'd3, 1'b0, 5'd3, 64'h10, 12'd0, 64'h0);
        b.mem_req_ready = 1'b1; tick; b.mem_req_ready = 1'b0;
        check("b_wait_exload", 64'(b.ex_is_load), 64'h1);
        rst_b = 1'b0;
        tick;
        rst_b = 1'b1;
        check("b_rst_exload", 64'(b.ex_is_load), 64'h0);
        check("b_rst_wbv", 64'(b.wb_valid), 64'h0);
        check("b_rst_mvalid", 64'(b.mem_req_valid), 64'h0);
        b.mem_rsp_valid = 1'b1; b.mem_rdata = 64'h1122334455667788;
        tick;
        b.mem_rsp_valid = 1'b0;
        check("b_late_rsp_wbv", 64'(b.wb_valid), 64'h0);
        check("b_rel_ready", 64'(b.req_ready), 64'h1);
        tick;
        check("b_late_rsp_wbv2", 64'(b.wb_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
